// File: rtl/nonce_sweep_ctrl.sv
// rtl/nonce_sweep_ctrl.sv - nonce sweep controller around a SHA-256 core
// Optional: define NONCE_STATS_EN to add the saturating attempts counter output.
module nonce_sweep_ctrl #(
  parameter int NONCE_WORD = 19,
  parameter int HASH_WORDS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] nonce_start,
  input  logic [31:0] nonce_end,
  input  logic [8:0]  difficulty,
  input  logic [15:0] message_addr,
  input  logic [15:0] output_addr,
  output logic        done,
  output logic        found,
  output logic [31:0] result_nonce,
`ifdef NONCE_STATS_EN
  output logic [31:0] attempts,
`endif
  output logic        sha_start,
  input  logic        sha_done,
  output logic        mem_sel,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_NONCE, S_KICK, S_WAIT_BUSY, S_WAIT_DONE, S_RD_HASH, S_CHECK
  } state_t;

  localparam logic [15:0] NONCE_OFS = 16'(NONCE_WORD);
  localparam logic [3:0]  RD_LAST   = 4'(HASH_WORDS);

  state_t      state, state_nxt;
  logic [31:0] nonce, nonce_end_q;
  logic [15:0] msg_addr_q, out_addr_q;
  logic [8:0]  diff_q;
  logic [3:0]  rd_cnt;
  logic        hash_fail;

  // Bits of word k (h0 = k 0, MSB first) that must be zero for difficulty d.
  function automatic logic [31:0] word_mask(input logic [8:0] d, input logic [3:0] k);
    logic [9:0] base;
    logic [9:0] rem;
    base = {1'b0, k, 5'b0};
    rem  = '0;
    if ({1'b0, d} <= base) begin
      word_mask = '0;
    end else begin
      rem = {1'b0, d} - base;
      if (rem >= 10'd32) word_mask = '1;
      else               word_mask = ~(32'hFFFF_FFFF >> rem[4:0]);
    end
  endfunction

  assign mem_clk = clk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    done           = 1'b0;
    sha_start      = 1'b0;
    mem_sel        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    case (state)
      S_IDLE: begin
        done = 1'b1;
        if (start) state_nxt = S_WR_NONCE;
      end
      S_WR_NONCE: begin
        mem_sel        = 1'b1;
        mem_we         = 1'b1;
        mem_addr       = msg_addr_q + NONCE_OFS;
        mem_write_data = nonce;
        state_nxt      = S_KICK;
      end
      S_KICK: begin
        sha_start = 1'b1;
        state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: if (!sha_done) state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (sha_done)  state_nxt = S_RD_HASH;
      S_RD_HASH: begin
        mem_sel  = 1'b1;
        mem_addr = out_addr_q + {12'b0, rd_cnt};
        if (rd_cnt == RD_LAST) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (!hash_fail || nonce == nonce_end_q) state_nxt = S_IDLE;
        else                                    state_nxt = S_WR_NONCE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      nonce        <= '0;
      nonce_end_q  <= '0;
      msg_addr_q   <= '0;
      out_addr_q   <= '0;
      diff_q       <= '0;
      rd_cnt       <= '0;
      hash_fail    <= 1'b0;
      found        <= 1'b0;
      result_nonce <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          nonce       <= nonce_start;
          nonce_end_q <= nonce_end;
          msg_addr_q  <= message_addr;
          out_addr_q  <= output_addr;
          diff_q      <= (difficulty > 9'd256) ? 9'd256 : difficulty;
          found       <= 1'b0;
        end
        S_WR_NONCE: begin
          rd_cnt    <= '0;
          hash_fail <= 1'b0;
        end
        S_RD_HASH: begin
          rd_cnt <= rd_cnt + 4'd1;
          // Data lags the address by one cycle, so count 1 carries word 0.
          if (rd_cnt != 4'd0)
            hash_fail <= hash_fail | (|(mem_read_data & word_mask(diff_q, rd_cnt - 4'd1)));
        end
        S_CHECK: begin
          if (!hash_fail) begin
            found        <= 1'b1;
            result_nonce <= nonce;
          end else if (nonce == nonce_end_q) begin
            found        <= 1'b0;
            result_nonce <= nonce;
          end else begin
            nonce <= nonce + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef NONCE_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                     attempts <= '0;
    else if (state == S_IDLE && start)                attempts <= '0;
    else if (state == S_CHECK && attempts != '1)      attempts <= attempts + 32'd1;
  end
`endif

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// tb/tb_nonce_sweep_ctrl.sv - scoreboard bench for nonce_sweep_ctrl with a stub hash core
module tb_nonce_sweep_ctrl;
  localparam logic [15:0] MSG = 16'h0100;
  localparam logic [15:0] OUT = 16'h0200;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] nonce_start = '0, nonce_end = '0;
  logic [8:0]  difficulty = '0;
  logic [15:0] message_addr = MSG, output_addr = OUT;
  logic        done, found, sha_start, sha_done;
  logic [31:0] result_nonce;
  logic        mem_sel, mem_clk, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data, mem_read_data;
`ifdef NONCE_STATS_EN
  logic [31:0] attempts;
`endif

  nonce_sweep_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .difficulty(difficulty),
    .message_addr(message_addr), .output_addr(output_addr),
    .done(done), .found(found), .result_nonce(result_nonce),
`ifdef NONCE_STATS_EN
    .attempts(attempts),
`endif
    .sha_start(sha_start), .sha_done(sha_done),
    .mem_sel(mem_sel), .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];
  int busy_cnt;
  int mode = 0;

  function automatic logic [31:0] stub_hash(input int m, input int k, input logic [31:0] n);
    case (m)
      0: return 32'hDEAD_0000 | 32'(k);
      1: return (k == 0 && n == 32'd7) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      2: return 32'h0;
      3: if (k == 0) return 32'h0;
         else if (k == 1) return (n == 32'd2) ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
         else return 32'hFFFF_FFFF;
      default: return (k == 7) ? 32'h1 : 32'h0;
    endcase
  endfunction

  // Shared memory plus stub core: busy for 5 cycles, then writes 8 hash words.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_cnt <= 0;
      sha_done <= 1'b1;
    end else begin
      if (mem_sel && mem_we) mem[mem_addr] <= mem_write_data;
      mem_read_data <= mem[mem_addr];
      if (sha_start) begin
        busy_cnt <= 5;
        sha_done <= 1'b0;
      end else if (busy_cnt != 0) begin
        busy_cnt <= busy_cnt - 1;
        if (busy_cnt == 1) begin
          for (int k = 0; k < 8; k++)
            mem[OUT + 16'(k)] <= stub_hash(mode, k, mem[MSG + 16'd19]);
          sha_done <= 1'b1;
        end
      end
    end
  end

  typedef struct {
    logic        found;
    logic [31:0] res;
    int          pulses;
    int          base;
  } comp_t;

  logic [31:0] exp_wr[$];
  comp_t       exp_comp[$];
  int checks = 0, errors = 0, total_pulses = 0;
  logic prev_done = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expectations as the DUT writes a nonce or finishes a sweep.
  initial begin
    logic [31:0] w;
    comp_t c;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (sha_start) total_pulses++;
        if (mem_sel && mem_we) begin
          if (exp_wr.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: got %0h expected none", mem_write_data);
          end else begin
            w = exp_wr.pop_front();
            chk("wr_addr", 64'(mem_addr), 64'(MSG + 16'd19));
            chk("wr_data", 64'(mem_write_data), 64'(w));
          end
        end
        if (done && !prev_done) begin
          if (exp_comp.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got result %0h expected none", result_nonce);
          end else begin
            c = exp_comp.pop_front();
            chk("found", 64'(found), 64'(c.found));
            chk("result_nonce", 64'(result_nonce), 64'(c.res));
            chk("sha_pulses", 64'(total_pulses - c.base), 64'(c.pulses));
`ifdef NONCE_STATS_EN
            chk("attempts", 64'(attempts), 64'(c.pulses));
`endif
          end
        end
      end
      prev_done = done;
    end
  end

  task automatic issue_sweep(input logic [31:0] ns, input logic [31:0] ne, input logic [8:0] d,
                             input int m, input logic ef, input logic [31:0] er);
    comp_t c;
    logic [31:0] n;
    int cnt;
    mode = m;
    n = ns;
    cnt = 0;
    while (cnt < 1000) begin
      exp_wr.push_back(n);
      cnt++;
      if (n == er) break;
      n = n + 32'd1;
    end
    c.found = ef; c.res = er; c.pulses = cnt; c.base = total_pulses;
    exp_comp.push_back(c);
    nonce_start = ns; nonce_end = ne; difficulty = d;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int i;
    tick();
    for (i = 0; i < 5000 && !done; i++) tick();
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got done=0 expected done=1", name);
    end
    tick();
    tick();
  endtask

  initial begin
    int i;
    #1;
    chk("rst_done", 64'(done), 64'd1);
    chk("rst_found", 64'(found), 64'd0);
    chk("rst_result", 64'(result_nonce), 64'd0);
    chk("rst_sha_start", 64'(sha_start), 64'd0);
    chk("rst_mem_sel", 64'(mem_sel), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_write_data), 64'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    issue_sweep(32'd5, 32'd5, 9'd0, 0, 1'b1, 32'd5);
    wait_done("single");
    chk("mem_nonce_word", 64'(mem[MSG + 16'd19]), 64'd5);

    issue_sweep(32'd0, 32'd3, 9'd256, 0, 1'b0, 32'd3);
    wait_done("exhaust");

    issue_sweep(32'd0, 32'd10, 9'd16, 1, 1'b1, 32'd7);
    wait_done("diff16");

    issue_sweep(32'hFFFF_FFFE, 32'h0000_0001, 9'd256, 0, 1'b0, 32'h0000_0001);
    wait_done("wrap");

    issue_sweep(32'd0, 32'd5, 9'd33, 3, 1'b1, 32'd2);
    wait_done("diff33");

    issue_sweep(32'd0, 32'd1, 9'd256, 4, 1'b0, 32'd1);
    wait_done("diff256_lsb");
    issue_sweep(32'd0, 32'd1, 9'd300, 4, 1'b0, 32'd1);
    wait_done("diff_clamp");
    issue_sweep(32'd0, 32'd1, 9'd255, 4, 1'b1, 32'd0);
    wait_done("diff255");
    issue_sweep(32'd3, 32'd6, 9'd256, 2, 1'b1, 32'd3);
    wait_done("zero_hash");

    // Reset while waiting for the core: only the first nonce write is expected.
    mode = 0;
    exp_wr.push_back(32'd0);
    nonce_start = 32'd0; nonce_end = 32'd3; difficulty = 9'd256;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (i = 0; i < 50 && !sha_start; i++) tick();
    chk("kick_seen", 64'(sha_start), 64'd1);
    tick(); tick(); tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_done", 64'(done), 64'd1);
    chk("midrst_mem_we", 64'(mem_we), 64'd0);
    chk("midrst_mem_sel", 64'(mem_sel), 64'd0);
    chk("midrst_sha_start", 64'(sha_start), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    issue_sweep(32'd9, 32'd9, 9'd256, 0, 1'b0, 32'd9);
    wait_done("after_reset");

    // A start pulse during hash read-back must not disturb the sweep.
    issue_sweep(32'd0, 32'd3, 9'd256, 0, 1'b0, 32'd3);
    for (i = 0; i < 200 && !(mem_sel && !mem_we); i++) tick();
    chk("in_rd_hash", 64'(mem_sel && !mem_we), 64'd1);
    nonce_start = 32'd100; nonce_end = 32'd200;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("start_ignored");

    chk("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
    chk("comp_queue_empty", 64'(exp_comp.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
